calc_seq_ctrl: RTL and testbench

//  Key-driven sequencer for the 4-digit calculator datapath. Takes decoded keypad events,

---
 rtl/calc_seq_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_ctrl.sv
// Key-driven sequencer for the 4-digit calculator.
// Builds decimal operands from keypad digits, latches the operator, runs a
// shared multi-cycle ALU through a start/done handshake, and chooses the
// value and error flag sent to the display path. Every output is registered.
module calc_seq_ctrl #(
  parameter int W       = 14,
  parameter int MAX_VAL = 9999,
  parameter int TIMEOUT = 64
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         key_vld,
  input  logic [3:0]   key_code,
  output logic         alu_start,
  output logic [1:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic         alu_done,
  input  logic [W-1:0] alu_result,
  input  logic         alu_err,
  output logic [W-1:0] disp_num,
  output logic         disp_err,
  output logic         busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_ENTER_A,
    S_OP,
    S_ENTER_B,
    S_EXEC,
    S_WAIT,
    S_RESULT,
    S_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   r_q, r_d;
  logic [1:0]     op_q, op_d;
  logic           pend_q, pend_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   disp_d;

  // Key classification
  logic         is_digit, is_op, is_eq, is_clr;
  logic [W-1:0] digit_w;
  logic [1:0]   key_op;
  logic         a_room, b_room, timeout_hit, pend_now, clear;

  assign is_digit    = key_vld && (key_code < 4'd10);
  assign is_op       = key_vld && (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_eq       = key_vld && (key_code == 4'd14);
  assign is_clr      = key_vld && (key_code == 4'd15);
  assign digit_w     = W'(key_code);
  assign key_op      = 2'(key_code - 4'd10);
  // Below 1000 another digit still fits in four decimal places.
  assign a_room      = a_q < W'(1000);
  assign b_room      = b_q < W'(1000);
  assign timeout_hit = cnt_q == CW'(TIMEOUT - 1);
  // A 'C' seen now or earlier during the ALU run both mean "clear when it ends".
  assign pend_now    = pend_q || is_clr;

  // x*10 + d without a multiplier; inputs are < 1000 so the sum never exceeds 9999.
  function automatic logic [W-1:0] acc10(input logic [W-1:0] x, input logic [W-1:0] d);
    return (x << 3) + (x << 1) + d;
  endfunction

  // Next-state, operand and display selection
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    op_d    = op_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    disp_d  = '0;

    unique case (state_q)
      S_ENTER_A: begin
        if (is_clr) clear = 1'b1;
        else if (is_digit) begin
          if (a_room) a_d = acc10(a_q, digit_w);
        end else if (is_op) begin
          op_d    = key_op;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (is_clr) clear = 1'b1;
        else if (is_digit) begin
          b_d     = digit_w;
          state_d = S_ENTER_B;
        end else if (is_op) op_d = key_op;
      end
      S_ENTER_B: begin
        if (is_clr) clear = 1'b1;
        else if (is_digit) begin
          if (b_room) b_d = acc10(b_q, digit_w);
        end else if (is_eq) begin
          // Divide by zero is caught here so the ALU is never launched for it.
          if (op_q == 2'b11 && b_q == '0) state_d = S_ERR;
          else                            state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_clr) pend_d = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done || timeout_hit) begin
          if (pend_now) clear = 1'b1;
          else if (alu_done) begin
            if (alu_err || alu_result > W'(MAX_VAL)) state_d = S_ERR;
            else begin
              r_d     = alu_result;
              state_d = S_RESULT;
            end
          end else state_d = S_ERR;
        end else begin
          pend_d = pend_now;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      S_RESULT: begin
        if (is_clr) clear = 1'b1;
        else if (is_digit) begin
          a_d     = digit_w;
          b_d     = '0;
          state_d = S_ENTER_A;
        end else if (is_op) begin
          a_d     = r_q;
          op_d    = key_op;
          state_d = S_OP;
        end
      end
      S_ERR: begin
        if (is_clr) clear = 1'b1;
      end
      default: clear = 1'b1;
    endcase

    if (clear) begin
      state_d = S_ENTER_A;
      a_d     = '0;
      b_d     = '0;
      r_d     = '0;
      op_d    = 2'b00;
      pend_d  = 1'b0;
      cnt_d   = '0;
    end

    unique case (state_d)
      S_ENTER_A, S_OP:          disp_d = a_d;
      S_ENTER_B, S_EXEC, S_WAIT: disp_d = b_d;
      S_RESULT:                 disp_d = r_d;
      default:                  disp_d = '0;
    endcase
  end

  // State, operand and registered-output update
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_ENTER_A;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      op_q      <= 2'b00;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      alu_start <= 1'b0;
      disp_num  <= '0;
      disp_err  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      r_q       <= r_d;
      op_q      <= op_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      alu_start <= (state_d == S_EXEC);
      disp_num  <= disp_d;
      disp_err  <= (state_d == S_ERR);
      busy      <= (state_d == S_EXEC) || (state_d == S_WAIT);
    end
  end

  // Operands and operator come straight from their registers; keys are dropped
  // during EXEC/WAIT so they stay stable for the whole ALU run.
  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: directed key sequences, with expected
// display values and ALU commands queued when stimulus is driven and popped
// when the design responds.
module tb_calc_seq_ctrl;

  localparam int W = 14;
  localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_MUL = 4'd12,
                         K_DIV = 4'd13, K_EQ = 4'd14, K_C = 4'd15;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         key_vld = 1'b0;
  logic [3:0]   key_code = '0;
  logic         alu_start;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_a, alu_b;
  logic         alu_done = 1'b0;
  logic [W-1:0] alu_result = '0;
  logic         alu_err = 1'b0;
  logic [W-1:0] disp_num;
  logic         disp_err;
  logic         busy;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } cmd_t;

  int   total = 0;
  int   bad   = 0;
  int   exp_q[$];
  cmd_t cmd_q[$];

  calc_seq_ctrl #(.W(W), .MAX_VAL(9999), .TIMEOUT(64)) dut (
    .Clk(Clk), .Rst(Rst), .key_vld(key_vld), .key_code(key_code),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .disp_num(disp_num), .disp_err(disp_err), .busy(busy)
  );

  always #10 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One key pulse; the expected display is queued at drive time and popped after the edge.
  task automatic press(input logic [3:0] k, input int exp);
    @(negedge Clk);
    key_vld  = 1'b1;
    key_code = k;
    exp_q.push_back(exp);
    @(negedge Clk);
    key_vld = 1'b0;
    check($sformatf("disp_after_key%0d", k), disp_num, exp_q.pop_front());
  endtask

  // '=' with an expected ALU command; alu_start must appear in the following cycle only.
  task automatic equals(input logic [1:0] op, input int a, input int b, input int exp_disp);
    cmd_t c;
    cmd_q.push_back('{op: op, a: W'(a), b: W'(b)});
    press(K_EQ, exp_disp);
    c = cmd_q.pop_front();
    check("alu_start_hi", alu_start, 1);
    check("busy_exec", busy, 1);
    check("alu_op", alu_op, c.op);
    check("alu_a", alu_a, c.a);
    check("alu_b", alu_b, c.b);
    @(negedge Clk);
    check("alu_start_lo", alu_start, 0);
  endtask

  // ALU completion after 'dly' idle cycles, then the visible outcome.
  task automatic finish(input int dly, input int res, input logic err,
                        input int exp_num, input logic exp_err);
    repeat (dly) @(negedge Clk);
    alu_done   = 1'b1;
    alu_result = W'(res);
    alu_err    = err;
    exp_q.push_back(exp_num);
    @(negedge Clk);
    alu_done = 1'b0;
    alu_err  = 1'b0;
    check("result_disp", disp_num, exp_q.pop_front());
    check("result_err", disp_err, exp_err);
    check("busy_done", busy, 0);
  endtask

  initial begin
    int n;
    // Reset state
    #2 Rst = 1'b1;
    #5;
    check("rst_disp", disp_num, 0);
    check("rst_err", disp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_start", alu_start, 0);
    check("rst_a", alu_a, 0);
    check("rst_op", alu_op, 0);
    @(negedge Clk);
    Rst = 1'b0;

    // Digit accumulation, fifth digit ignored
    press(4'd1, 1); press(4'd2, 12); press(4'd3, 123); press(4'd4, 1234); press(4'd5, 1234);
    press(K_C, 0);

    // 12 + 34 = 46, then a digit from RESULT starts a fresh A
    press(4'd1, 1); press(4'd2, 12); press(K_ADD, 12); press(4'd3, 3); press(4'd4, 34);
    equals(2'b00, 12, 34, 34);
    finish(2, 46, 1'b0, 46, 1'b0);
    press(4'd8, 8);
    press(K_C, 0);

    // '=' ignored in ENTER_A; divide by zero goes straight to ERR without launching
    press(K_EQ, 0);
    check("eq_ignored_busy", busy, 0);
    press(4'd9, 9); press(K_DIV, 9); press(4'd0, 0); press(K_EQ, 0);
    check("div0_err", disp_err, 1);
    check("div0_nostart", alu_start, 0);
    check("div0_busy", busy, 0);
    @(negedge Clk);
    check("div0_nostart2", alu_start, 0);
    press(4'd7, 0);
    check("err_holds", disp_err, 1);
    press(K_C, 0);
    check("clr_err", disp_err, 0);

    // 99*99 = 9801, chained 9801-1 = 9800
    press(4'd9, 9); press(4'd9, 99); press(K_MUL, 99); press(4'd9, 9); press(4'd9, 99);
    equals(2'b10, 99, 99, 99);
    finish(3, 9801, 1'b0, 9801, 1'b0);
    press(K_SUB, 9801); press(4'd1, 1);
    equals(2'b01, 9801, 1, 1);
    finish(1, 9800, 1'b0, 9800, 1'b0);
    press(K_C, 0);

    // Timeout: 64 cycles in WAIT without alu_done
    press(4'd5, 5); press(K_ADD, 5); press(4'd5, 5);
    equals(2'b00, 5, 5, 5);
    repeat (60) @(negedge Clk);
    check("wait_busy", busy, 1);
    n = 0;
    while (disp_err !== 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("timeout_err", disp_err, 1);
    check("timeout_cycle", n, 4);
    check("timeout_busy", busy, 0);
    press(K_C, 0);

    // Result above MAX_VAL and ALU error both show ERR
    press(4'd5, 5); press(K_ADD, 5); press(4'd5, 5);
    equals(2'b00, 5, 5, 5);
    finish(2, 10000, 1'b0, 0, 1'b1);
    press(K_C, 0);
    press(4'd3, 3); press(K_SUB, 3); press(4'd5, 5);
    equals(2'b01, 3, 5, 5);
    finish(0, 0, 1'b1, 0, 1'b1);
    press(K_C, 0);

    // 'C' during WAIT: completion goes straight to cleared ENTER_A
    press(4'd7, 7); press(K_MUL, 7); press(4'd2, 2);
    equals(2'b10, 7, 2, 2);
    press(K_C, 2);
    check("pend_busy", busy, 1);
    finish(5, 14, 1'b0, 0, 1'b0);
    check("pend_a", alu_a, 0);
    check("pend_b", alu_b, 0);
    press(4'd3, 3);
    press(K_C, 0);

    // Async reset in WAIT; a late alu_done is ignored
    press(4'd4, 4); press(K_ADD, 4); press(4'd4, 4);
    equals(2'b00, 4, 4, 4);
    #3 Rst = 1'b1;
    #1;
    check("rstw_busy", busy, 0);
    check("rstw_disp", disp_num, 0);
    check("rstw_a", alu_a, 0);
    @(negedge Clk);
    Rst = 1'b0;
    finish(1, 8, 1'b0, 0, 1'b0);
    press(4'd6, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
